// File: rtl/jump_fetch_sequencer_pkg.sv
// Shared types and defaults for the J1/J2 jump-address fetch sequencer.
package relay_seq_pkg;

  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 16;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_LD1  = 3'd2,
    S_RD2  = 3'd3,
    S_LD2  = 3'd4,
    S_JMP  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } seq_state_t;

  function automatic logic is_read_state(input seq_state_t s);
    return (s == S_RD1) || (s == S_RD2);
  endfunction

endpackage

// File: rtl/jump_fetch_sequencer_if.sv
// Decoder/memory/bus bundle between the jump fetch sequencer and its environment.
interface jump_fetch_sequencer_if
  import relay_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic          start;
  logic          take_jump;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] j_in;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_rd;
  logic [AW-1:0] addr_out;
  logic          addr_drive;
  logic [DW-1:0] data_out;
  logic          data_drive;
  logic          ldJ1;
  logic          ldJ2;
  logic          ld_pc;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, take_jump, pc_in, j_in, mem_rdata, mem_ready,
    output mem_rd, addr_out, addr_drive, data_out, data_drive,
           ldJ1, ldJ2, ld_pc, busy, done, err
  );

  modport slave (
    output start, take_jump, pc_in, j_in, mem_rdata, mem_ready,
    input  mem_rd, addr_out, addr_drive, data_out, data_drive,
           ldJ1, ldJ2, ld_pc, busy, done, err
  );

endinterface

// File: rtl/jump_fetch_sequencer_addr_incrementer.sv
// AW-bit +1 with natural wrap; also used on the PC increment path.
module addr_incrementer
  import relay_seq_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] i_val,
  output logic [AW-1:0] o_val
);

  assign o_val = i_val + AW'(1);

endmodule

// File: rtl/jump_fetch_sequencer.sv
// Fetches the two immediate bytes of a GOTO/CALL into J1/J2, then optionally loads J into the PC.
module jump_fetch_sequencer
  import relay_seq_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  jump_fetch_sequencer_if.master bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  seq_state_t    r_state;
  seq_state_t    w_next_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_byte;
  logic [WCW-1:0] r_wait;
  logic          r_take;
  logic          r_err;
  logic [AW-1:0] w_inc_in;
  logic [AW-1:0] w_inc_out;
  logic          w_timeout;

  // One incrementer serves both the pc_in+1 capture and the per-byte advance.
  assign w_inc_in  = (r_state == S_IDLE) ? bus.pc_in : r_addr;
  assign w_timeout = (r_wait == WCW'(MAX_WAIT - 1));

  addr_incrementer #(.AW(AW)) u_addr_inc (
    .i_val (w_inc_in),
    .o_val (w_inc_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_byte <= '0;
      r_wait <= '0;
      r_take <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_addr <= w_inc_out;
          r_take <= bus.take_jump;
          r_err  <= 1'b0;
          r_wait <= '0;
        end
      end else if (is_read_state(r_state)) begin
        if (bus.mem_ready) begin
          r_byte <= bus.mem_rdata;
          r_wait <= '0;
        end else if (w_timeout) begin
          r_err  <= 1'b1;
          r_wait <= '0;
        end else begin
          r_wait <= r_wait + WCW'(1);
        end
      end else if ((r_state == S_LD1) || (r_state == S_LD2)) begin
        r_addr <= w_inc_out;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = bus.start ? S_RD1 : S_IDLE;
      S_RD1: begin
        if (bus.mem_ready)  w_next_state = S_LD1;
        else if (w_timeout) w_next_state = S_ERR;
        else                w_next_state = S_RD1;
      end
      S_LD1:   w_next_state = S_RD2;
      S_RD2: begin
        if (bus.mem_ready)  w_next_state = S_LD2;
        else if (w_timeout) w_next_state = S_ERR;
        else                w_next_state = S_RD2;
      end
      S_LD2:   w_next_state = r_take ? S_JMP : S_DONE;
      S_JMP:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      S_ERR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Buses are driven strictly one at a time, so each load strobe sees a stable source.
  always_comb begin
    bus.mem_rd     = 1'b0;
    bus.addr_out   = '0;
    bus.addr_drive = 1'b0;
    bus.data_out   = '0;
    bus.data_drive = 1'b0;
    bus.ldJ1       = 1'b0;
    bus.ldJ2       = 1'b0;
    bus.ld_pc      = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (r_state)
      S_RD1, S_RD2: begin
        bus.addr_out   = r_addr;
        bus.addr_drive = 1'b1;
        bus.mem_rd     = 1'b1;
        bus.busy       = 1'b1;
      end
      S_LD1: begin
        bus.data_out   = r_byte;
        bus.data_drive = 1'b1;
        bus.ldJ1       = 1'b1;
        bus.busy       = 1'b1;
      end
      S_LD2: begin
        bus.data_out   = r_byte;
        bus.data_drive = 1'b1;
        bus.ldJ2       = 1'b1;
        bus.busy       = 1'b1;
      end
      S_JMP: begin
        // j_in is the register unit's flopped {J1,J2}, already updated by the two loads.
        bus.addr_out   = bus.j_in;
        bus.addr_drive = 1'b1;
        bus.ld_pc      = 1'b1;
        bus.busy       = 1'b1;
      end
      S_DONE: begin
        bus.addr_out   = r_addr;
        bus.done       = 1'b1;
        bus.busy       = 1'b1;
      end
      default: begin
        bus.busy       = 1'b0;
      end
    endcase
  end

  assign bus.err = r_err;

endmodule

// File: tb/tb_jump_fetch_sequencer.sv
// Vector table plus scoreboard bench for jump_fetch_sequencer with a wait-state memory and J register model.
module tb_jump_fetch_sequencer;

  localparam int EV_RD   = 0;
  localparam int EV_J1   = 1;
  localparam int EV_J2   = 2;
  localparam int EV_PC   = 3;
  localparam int EV_DONE = 4;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic        take;
    int          waits;
    logic        restart;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] fin;
    int          lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   viol = 0;
  bit   sb_en = 1'b1;
  ev_t  sb_q[$];
  vec_t vecs[7];

  logic [15:0] mem_a1 = 16'h0000;
  logic [15:0] mem_a2 = 16'h0000;
  logic [7:0]  mem_d1 = 8'h00;
  logic [7:0]  mem_d2 = 8'h00;
  int          wait_cfg = 0;
  int          wait_ctr = 0;
  logic        prev_j1 = 1'b0;
  logic        prev_j2 = 1'b0;
  logic        prev_pc = 1'b0;
  logic [15:0] j_reg = 16'h0000;

  jump_fetch_sequencer_if #(.DW(8), .AW(16)) bus ();

  jump_fetch_sequencer #(.DW(8), .AW(16), .MAX_WAIT(15)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Register unit model: J1 is the high byte, J2 the low byte.
  always @(posedge clock) begin
    if (bus.ldJ1) j_reg[15:8] <= bus.data_out;
    if (bus.ldJ2) j_reg[7:0]  <= bus.data_out;
  end
  assign bus.j_in = j_reg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_ev(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [15:0] val);
    ev_t e;
    if (sb_en) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: event %0d value %0h, nothing expected", kind, val);
      end else begin
        e = sb_q.pop_front();
        chk("sb_kind", 64'(kind), 64'(e.kind));
        chk("sb_val", 64'(val), 64'(e.val));
      end
    end
  endtask

  function automatic logic [7:0] mem_read(input logic [15:0] a);
    if (a == mem_a1) return mem_d1;
    else if (a == mem_a2) return mem_d2;
    else return 8'hEE;
  endfunction

  // Monitor first, then decide this cycle's memory response.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.addr_drive && bus.data_drive) viol++;
      if ((int'(bus.ldJ1) + int'(bus.ldJ2) + int'(bus.ld_pc)) > 1) viol++;
      if ((bus.ldJ1 || bus.ldJ2) && !bus.data_drive) viol++;
      if (bus.ld_pc && !bus.addr_drive) viol++;
      if ((bus.ldJ1 && prev_j1) || (bus.ldJ2 && prev_j2) || (bus.ld_pc && prev_pc)) viol++;
      if (bus.ldJ1) sb_check(EV_J1, {8'h00, bus.data_out});
      if (bus.ldJ2) sb_check(EV_J2, {8'h00, bus.data_out});
      if (bus.ld_pc) sb_check(EV_PC, bus.addr_out);
      if (bus.done) sb_check(EV_DONE, bus.addr_out);
      if (bus.mem_rd) begin
        if (wait_ctr == wait_cfg) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_read(bus.addr_out);
          sb_check(EV_RD, bus.addr_out);
          wait_ctr = 0;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 8'h00;
          wait_ctr++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'h00;
        wait_ctr = 0;
      end
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 8'h00;
      wait_ctr = 0;
    end
    prev_j1 = bus.ldJ1;
    prev_j2 = bus.ldJ2;
    prev_pc = bus.ld_pc;
  end

  function automatic logic [63:0] all_outs();
    return 64'({bus.mem_rd, bus.addr_out, bus.addr_drive, bus.data_out, bus.data_drive,
                bus.ldJ1, bus.ldJ2, bus.ld_pc, bus.busy, bus.done, bus.err});
  endfunction

  task automatic run_vec(input vec_t v);
    int   t0;
    int   t_done;
    int   v0;
    logic seen;
    mem_a1 = v.a1; mem_d1 = v.b1;
    mem_a2 = v.a2; mem_d2 = v.b2;
    wait_cfg = v.waits;
    push_ev(EV_RD, v.a1);
    push_ev(EV_J1, {8'h00, v.b1});
    push_ev(EV_RD, v.a2);
    push_ev(EV_J2, {8'h00, v.b2});
    if (v.take) push_ev(EV_PC, {v.b1, v.b2});
    push_ev(EV_DONE, v.fin);
    v0 = viol;
    @(negedge clock);
    bus.pc_in = v.pc;
    bus.take_jump = v.take;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    bus.start = 1'b0;
    bus.take_jump = ~v.take;
    bus.pc_in = 16'h5A5A;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("err_clear_on_start", 64'(bus.err), 64'd0);
    seen = 1'b0;
    t_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      bus.start = (v.restart && (i == 1)) ? 1'b1 : 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        t_done = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(t_done - t0), 64'(v.lat));
    @(negedge clock);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("idle_after_done", 64'(bus.busy), 64'd0);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    chk("protocol", 64'(viol - v0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    //            pc        b1     b2     tk    w  rs    a1        a2        fin       lat
    vecs[0] = '{16'h0100, 8'h12, 8'h34, 1'b1, 0, 1'b0, 16'h0101, 16'h0102, 16'h0103, 6};
    vecs[1] = '{16'h0100, 8'h12, 8'h34, 1'b0, 0, 1'b0, 16'h0101, 16'h0102, 16'h0103, 5};
    vecs[2] = '{16'hFFFE, 8'hAB, 8'hCD, 1'b1, 0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 6};
    vecs[3] = '{16'h0200, 8'h56, 8'h78, 1'b1, 3, 1'b0, 16'h0201, 16'h0202, 16'h0203, 12};
    vecs[4] = '{16'h0200, 8'h9A, 8'hBC, 1'b0, 3, 1'b1, 16'h0201, 16'h0202, 16'h0203, 11};
    vecs[5] = '{16'hFFFF, 8'hC3, 8'h3C, 1'b1, 1, 1'b0, 16'h0000, 16'h0001, 16'h0002, 8};
    vecs[6] = '{16'h7FFD, 8'h01, 8'hFE, 1'b1, 0, 1'b1, 16'h7FFE, 16'h7FFF, 16'h8000, 6};

    bus.start = 1'b0;
    bus.take_jump = 1'b0;
    bus.pc_in = 16'h0000;
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_reset_outputs", all_outs(), 64'd0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Memory that never answers must time out into a sticky err.
    sb_en = 1'b0;
    wait_cfg = 1000;
    @(negedge clock);
    bus.pc_in = 16'h0300;
    bus.take_jump = 1'b1;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.err) break;
    end
    chk("timeout_err", 64'(bus.err), 64'd1);
    chk("timeout_latency", 64'(cyc - t0), 64'd16);
    chk("timeout_busy", 64'(bus.busy), 64'd0);
    @(negedge clock);
    chk("err_sticky", 64'(bus.err), 64'd1);
    chk("err_idle_outputs", all_outs(), 64'd1);
    sb_q.delete();
    sb_en = 1'b1;
    run_vec(vecs[1]);
    chk("err_stays_clear", 64'(bus.err), 64'd0);

    // Asynchronous reset in the middle of LD1.
    sb_en = 1'b0;
    mem_a1 = 16'h0101; mem_d1 = 8'h12;
    mem_a2 = 16'h0102; mem_d2 = 8'h34;
    wait_cfg = 0;
    @(negedge clock);
    bus.pc_in = 16'h0100;
    bus.take_jump = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ldJ1) break;
      @(negedge clock);
    end
    chk("reached_ld1", 64'(bus.ldJ1), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ldJ1_drop", 64'(bus.ldJ1), 64'd0);
    chk("rst_mid_outputs", all_outs(), 64'd0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_hold_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;
    sb_q.delete();
    sb_en = 1'b1;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
